ram_dp_port_master: RTL and testbench
=====================================

RAM_DP_PORT_MASTER -- requirements
Module: ram_dp_port_master

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, RAM data word width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 16, RAM address width.
REQ-003 SHALL have parameter RAM_DEPTH, default 256, number of RAM words; RAM_DEPTH <= 2**ADDR_WIDTH.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port req_valid  input  1  request present.
REQ-007 SHALL have port req_ready  output  1  request accepted on an edge where req_valid && req_ready.
REQ-008 SHALL have port req_we  input  1  1 = write, 0 = read.
REQ-009 SHALL have port req_addr  input  ADDR_WIDTH  request address.
REQ-010 SHALL have port req_wdata  input  DATA_WIDTH  write data.
REQ-011 SHALL have port rsp_valid  output  1  one-cycle pulse, rsp_rdata valid.
REQ-012 SHALL have port rsp_rdata  output  DATA_WIDTH  read data.
REQ-013 SHALL have port init_busy  output  1  memory clear in progress.
REQ-014 SHALL have port ram_address  output  ADDR_WIDTH  to RAM port address.
REQ-015 SHALL have port ram_data  inout  DATA_WIDTH  to RAM port bidirectional data.
REQ-016 SHALL have ports ram_cs, ram_we, ram_oe  output  1 each  RAM chip select, write enable, output enable.

Function
REQ-017 SHALL implement FSM states IDLE, WRITE, READ_ADDR, READ_CAP, INIT; all RAM-side outputs registered.
REQ-018 SHALL drive req_ready = 1 in IDLE and WRITE, 0 in READ_ADDR, READ_CAP, INIT.
REQ-019 On accept with req_we=1: latch addr/wdata, next state WRITE; with req_we=0: latch addr, next state READ_ADDR.
REQ-020 WRITE: ram_cs=1, ram_we=1, ram_oe=0, ram_data driven with latched wdata for exactly one cycle; back-to-back writes sustain 1 write/cycle.
REQ-021 WRITE with no new accept -> IDLE; accept of a read in WRITE -> READ_ADDR.
REQ-022 READ_ADDR and READ_CAP: ram_cs=1, ram_we=0, ram_oe=1, ram_data released (high-Z); READ_ADDR -> READ_CAP -> IDLE unconditionally.
REQ-023 SHALL sample ram_data at the end of READ_CAP into rsp_rdata and assert rsp_valid for exactly the following cycle; rsp_rdata holds until next read.
REQ-024 Read latency: rsp_valid high 3 cycles after the accepting edge; read throughput 1 per 3 cycles.
REQ-025 IDLE: ram_cs=ram_we=ram_oe=0, ram_address holds last value, ram_data high-Z.
REQ-026 SHALL drive ram_data only when ram_we=1; never drive it while ram_oe=1 (no bus contention).
REQ-027 No backpressure on response: rsp_valid is not gated by any input; a request accepted while rsp_valid=1 proceeds normally.
REQ-028 Address and wdata SHALL be taken verbatim, no wrap or range check; out-of-range addresses pass through.

Reset
REQ-029 While rst=1 at an edge: state <= INIT if RAM_DP_MASTER_INIT_CLEAR_EN defined, else IDLE; ram_cs, ram_we, ram_oe, rsp_valid <= 0; ram_address, rsp_rdata <= 0; ram_data high-Z.
REQ-030 Reset mid-read SHALL discard the transaction with no rsp_valid pulse; reset mid-INIT SHALL restart the clear from address 0.

Configuration
REQ-031 Macro RAM_DP_MASTER_INIT_CLEAR_EN defined: after reset, INIT writes 0 to addresses 0..RAM_DEPTH-1, one per cycle (ram_cs=ram_we=1), init_busy=1, req_ready=0, then IDLE; clear takes RAM_DEPTH cycles.
REQ-032 Macro undefined: no INIT state logic, init_busy constant 0, first cycle after reset is IDLE with req_ready=1.

Verification
REQ-033 Write addr 0x0010 data 0xA5, then read 0x0010 -> rsp_valid pulse 3 cycles after read accept, rsp_rdata=0xA5.
REQ-034 Four back-to-back writes 0x0000..0x0003 data 0x11..0x44 -> ram_cs=ram_we=1 four consecutive cycles; reads return 0x11,0x22,0x33,0x44.
REQ-035 Read request held valid continuously -> req_ready low 2 cycles per read; no ram_data contention (never X) throughout.
REQ-036 rst asserted in READ_CAP of read from 0x0005 -> no rsp_valid, ram_cs=0 next cycle, req_ready=1 (macro off).
REQ-037 Macro on: preload 0xFF at 0x00FF, reset -> init_busy high 256 cycles, then read 0x00FF returns 0x00.
REQ-038 Write 0x3C to 0x0020 accepted the same cycle rsp_valid pulses for a prior read -> both complete, response data unaffected.

Source files
------------

// File: rtl/ram_dp_port_master.sv
// Request/response front end for a single-port asynchronous SRAM with a shared bidirectional data bus.
// Define RAM_DP_MASTER_INIT_CLEAR_EN to zero the whole RAM after every reset.
module ram_dp_port_master #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 16,
  parameter int RAM_DEPTH  = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  init_busy,
  output logic [ADDR_WIDTH-1:0] ram_address,
  inout  wire  [DATA_WIDTH-1:0] ram_data,
  output logic                  ram_cs,
  output logic                  ram_we,
  output logic                  ram_oe
);

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ_ADDR,
    READ_CAP,
    INIT
  } state_t;

`ifdef RAM_DP_MASTER_INIT_CLEAR_EN
  localparam state_t                  RESET_STATE = INIT;
  localparam logic [ADDR_WIDTH-1:0]   LAST_ADDR   = ADDR_WIDTH'(RAM_DEPTH - 1);
`else
  localparam state_t                  RESET_STATE = IDLE;
`endif

  state_t                  r_state;
  logic                    r_ram_cs;
  logic                    r_ram_we;
  logic                    r_ram_oe;
  logic [ADDR_WIDTH-1:0]   r_ram_address;
  logic [DATA_WIDTH-1:0]   r_ram_wdata;
  logic                    r_rsp_valid;
  logic [DATA_WIDTH-1:0]   r_rsp_rdata;

  state_t                  w_next_state;
  logic                    w_accept;
  logic                    w_cs;
  logic                    w_we;
  logic                    w_oe;
  logic [ADDR_WIDTH-1:0]   w_address;
  logic [DATA_WIDTH-1:0]   w_wdata;

`ifdef RAM_DP_MASTER_INIT_CLEAR_EN
  logic [ADDR_WIDTH-1:0]   r_init_addr;

  // Clear pointer restarts from zero on every reset, including one that lands mid-clear.
  always_ff @(posedge clk) begin
    if (rst)
      r_init_addr <= '0;
    else if (r_state == INIT)
      r_init_addr <= r_init_addr + ADDR_WIDTH'(1);
  end

  assign init_busy = (r_state == INIT);
`else
  assign init_busy = 1'b0;
`endif

  assign req_ready = (r_state == IDLE) || (r_state == WRITE);
  assign w_accept  = req_valid && req_ready;

  // The bus strobes for the coming cycle are decoded here and registered below, so the
  // RAM pins never glitch on a state change.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves a latch behind.
    w_next_state = r_state;
    w_cs         = 1'b0;
    w_we         = 1'b0;
    w_oe         = 1'b0;
    w_address    = r_ram_address;
    w_wdata      = r_ram_wdata;

    case (r_state)
      IDLE, WRITE: begin
        w_next_state = IDLE;
        if (w_accept) begin
          w_cs      = 1'b1;
          w_address = req_addr;
          if (req_we) begin
            w_next_state = WRITE;
            w_we         = 1'b1;
            w_wdata      = req_wdata;
          end else begin
            w_next_state = READ_ADDR;
            w_oe         = 1'b1;
          end
        end
      end

      READ_ADDR: begin
        w_next_state = READ_CAP;
        w_cs         = 1'b1;
        w_oe         = 1'b1;
      end

      READ_CAP: begin
        w_next_state = IDLE;
      end

`ifdef RAM_DP_MASTER_INIT_CLEAR_EN
      INIT: begin
        w_cs      = 1'b1;
        w_we      = 1'b1;
        w_address = r_init_addr;
        w_wdata   = '0;
        if (r_init_addr == LAST_ADDR)
          w_next_state = IDLE;
      end
`endif

      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every register updating from pre-edge values.
    if (rst) begin
      r_state       <= RESET_STATE;
      r_ram_cs      <= 1'b0;
      r_ram_we      <= 1'b0;
      r_ram_oe      <= 1'b0;
      r_ram_address <= '0;
      r_ram_wdata   <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= '0;
    end else begin
      r_state       <= w_next_state;
      r_ram_cs      <= w_cs;
      r_ram_we      <= w_we;
      r_ram_oe      <= w_oe;
      r_ram_address <= w_address;
      r_ram_wdata   <= w_wdata;
      r_rsp_valid   <= (r_state == READ_CAP);
      // Capture at the close of READ_CAP gives the RAM a full two cycles of access time.
      if (r_state == READ_CAP)
        r_rsp_rdata <= ram_data;
    end
  end

  // The data bus is driven only during write cycles; reads leave it floating for the RAM.
  assign ram_data    = r_ram_we ? r_ram_wdata : {DATA_WIDTH{1'bz}};

  assign ram_cs      = r_ram_cs;
  assign ram_we      = r_ram_we;
  assign ram_oe      = r_ram_oe;
  assign ram_address = r_ram_address;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_rdata   = r_rsp_rdata;

endmodule

// File: tb/tb_ram_dp_port_master.sv
// Directed bench for ram_dp_port_master with a behavioural async SRAM on the shared data bus.
// Also covers the clear-on-reset build when RAM_DP_MASTER_INIT_CLEAR_EN is defined.
module tb_ram_dp_port_master;

  localparam int DW    = 8;
  localparam int AW    = 16;
  localparam int DEPTH = 256;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          init_busy;
  logic [AW-1:0] ram_address;
  wire  [DW-1:0] ram_data;
  logic          ram_cs;
  logic          ram_we;
  logic          ram_oe;

  int checks = 0;
  int errors = 0;
  int contention_cnt = 0;

  always #5 clk = ~clk;

  ram_dp_port_master #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .RAM_DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .init_busy  (init_busy),
    .ram_address(ram_address),
    .ram_data   (ram_data),
    .ram_cs     (ram_cs),
    .ram_we     (ram_we),
    .ram_oe     (ram_oe)
  );

  // Asynchronous-read SRAM: drives the bus while selected and output-enabled, writes on the edge.
  logic [DW-1:0] mem [DEPTH];
  assign ram_data = (ram_cs && ram_oe && !ram_we) ? mem[ram_address[7:0]] : 'z;
  always @(posedge clk)
    if (ram_cs && ram_we)
      mem[ram_address[7:0]] <= ram_data;

  always @(negedge clk)
    if (ram_we && ram_oe)
      contention_cnt++;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;  // write data, or expected read data
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready)
      check("ready_timeout", req_ready, 1);
  endtask

  // Called on a negedge; returns on the negedge of the write bus cycle after checking it.
  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input string name);
    wait_ready();
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = a;
    req_wdata = d;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check({name, "_cs_we"}, {ram_cs, ram_we, ram_oe}, 3'b110);
    check({name, "_addr"}, ram_address, a);
    check({name, "_bus"}, ram_data, d);
  endtask

  // Called on a negedge; returns on the negedge of the rsp_valid cycle.
  task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] exp, input string name);
    int n;
    wait_ready();
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = a;
    @(posedge clk);
    #1 req_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rsp_valid && n < 10);
    check({name, "_latency"}, n, 3);
    check({name, "_data"}, rsp_rdata, exp);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;

    vecs[0] = '{1'b1, 16'h0010, 8'hA5};
    vecs[1] = '{1'b0, 16'h0010, 8'hA5};
    vecs[2] = '{1'b1, 16'h1234, 8'h5A};
    vecs[3] = '{1'b0, 16'h1234, 8'h5A};
    vecs[4] = '{1'b1, 16'h00FF, 8'hC3};
    vecs[5] = '{1'b0, 16'h00FF, 8'hC3};
    vecs[6] = '{1'b0, 16'h0010, 8'hA5};

    rst       = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_strobes", {ram_cs, ram_we, ram_oe}, 3'b000);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_address", ram_address, 0);
    check("rst_rdata", rsp_rdata, 0);
`ifdef RAM_DP_MASTER_INIT_CLEAR_EN
    check("rst_ready", req_ready, 0);
    check("rst_init_busy", init_busy, 1);
    rst = 1'b0;
    n = 0;
    while (init_busy && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("init_done", init_busy, 0);
`else
    check("rst_ready", req_ready, 1);
    check("rst_init_busy", init_busy, 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_after_rst", {req_ready, ram_cs}, 2'b10);
`endif

    // Single transactions from the vector table, including an out-of-range address.
    foreach (vecs[i]) begin
      if (vecs[i].we)
        do_write(vecs[i].addr, vecs[i].data, $sformatf("vec%0d_wr", i));
      else
        do_read(vecs[i].addr, vecs[i].data, $sformatf("vec%0d_rd", i));
    end

    // Four back-to-back writes: one bus write per cycle.
    wait_ready();
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 16'h0000;
    req_wdata = 8'h11;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("b2b%0d_strobes", i), {ram_cs, ram_we, ram_oe, req_ready}, 4'b1101);
      check($sformatf("b2b%0d_addr", i), ram_address, i);
      check($sformatf("b2b%0d_bus", i), ram_data, (i + 1) * 8'h11);
      if (i < 3) begin
        req_addr  = AW'(i + 1);
        req_wdata = DW'((i + 2) * 8'h11);
      end else begin
        req_valid = 1'b0;
      end
    end
    @(negedge clk);
    check("b2b_idle", {ram_cs, ram_we}, 2'b00);
    for (int i = 0; i < 4; i++)
      do_read(AW'(i), DW'((i + 1) * 8'h11), $sformatf("b2b_rd%0d", i));

    // Read request held valid: ready low for two cycles of every three.
    wait_ready();
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 16'h0001;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      check($sformatf("stream%0d_ready", k), req_ready, (k % 3 == 0));
      check($sformatf("stream%0d_rsp", k), rsp_valid, (k % 3 == 0));
      if (k % 3 == 0)
        check($sformatf("stream%0d_data", k), rsp_rdata, 8'h22);
      if (k == 9)
        req_valid = 1'b0;
    end

    // Write accepted in the same cycle that a read response is presented.
    wait_ready();
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 16'h0010;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("ovl_rsp_valid", {rsp_valid, req_ready}, 2'b11);
    check("ovl_rsp_data", rsp_rdata, 8'hA5);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 16'h0020;
    req_wdata = 8'h3C;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("ovl_wr_strobes", {ram_cs, ram_we, ram_oe}, 3'b110);
    check("ovl_wr_addr", ram_address, 16'h0020);
    check("ovl_wr_bus", ram_data, 8'h3C);
    check("ovl_rsp_done", rsp_valid, 0);
    check("ovl_rdata_hold", rsp_rdata, 8'hA5);
    do_read(16'h0020, 8'h3C, "ovl_rd");

`ifdef RAM_DP_MASTER_INIT_CLEAR_EN
    // Reset clears the whole RAM, one word per cycle.
    do_write(16'h00FF, 8'hFF, "pre_wr");
    do_read(16'h00FF, 8'hFF, "pre_rd");
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    while (init_busy && n < 1000) begin
      n++;
      if (n == 100) begin
        check("init_strobes", {ram_cs, ram_we, ram_oe, req_ready}, 4'b1100);
        check("init_addr", ram_address, 98);
        check("init_bus", ram_data, 0);
      end
      @(negedge clk);
    end
    check("init_cycles", n, DEPTH);
    do_read(16'h00FF, 8'h00, "clr_rd_ff");
    do_read(16'h0010, 8'h00, "clr_rd_10");
`else
    // Reset during READ_CAP abandons the read.
    wait_ready();
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 16'h0005;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("abort_read_addr", {ram_cs, ram_oe, ram_we}, 3'b110);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_no_rsp", rsp_valid, 0);
    check("abort_cs", ram_cs, 0);
    check("abort_ready", req_ready, 1);
    rst = 1'b0;
    @(negedge clk);
    check("abort_no_late_rsp", rsp_valid, 0);
    do_read(16'h0010, 8'hA5, "abort_recover");
`endif

    check("no_bus_contention", contention_cnt, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
